// File: rtl/vga_timing_decoder_if.sv
// Bundle between a VGA pixel source and the timing decoder:
// sync/colour inputs plus recovered timing, strobes and error flags.
interface vga_timing_decoder_if;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [9:0]  rec_x;
    logic [9:0]  rec_y;
    logic        rec_video_on;
    logic        pix_valid;
    logic [11:0] pix_rgb;
    logic        locked;
    logic        err_line;
    logic        err_hsw;
    logic        err_frame;
    logic        err_nosync;
    logic [7:0]  err_count;

    modport master (
        output hsync, vsync, rgb,
        input  rec_x, rec_y, rec_video_on, pix_valid, pix_rgb,
        input  locked, err_line, err_hsw, err_frame, err_nosync,
        input  err_count
    );

    modport slave (
        input  hsync, vsync, rgb,
        output rec_x, rec_y, rec_video_on, pix_valid, pix_rgb,
        output locked, err_line, err_hsw, err_frame, err_nosync,
        output err_count
    );
endinterface

// File: rtl/vga_timing_decoder.sv
// Recovers pixel position from sampled VGA hsync/vsync, checks timing,
// tracks lock over clean frames and strobes captured active pixels.
module vga_timing_decoder #(
    parameter int CLK_PER_PIX = 4,
    parameter int H_TOTAL     = 800,
    parameter int HS_W        = 96,
    parameter int H_OFFSET    = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_OFFSET    = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    vga_timing_decoder_if.slave bus
);
    localparam logic [13:0] LINE_CLKS = 14'(H_TOTAL * CLK_PER_PIX);
    localparam logic [13:0] HSW_CLKS  = 14'(HS_W * CLK_PER_PIX);
    localparam logic [12:0] NOSYNC_M1 = 13'(2 * H_TOTAL * CLK_PER_PIX - 1);
    localparam logic [3:0]  DIV_MAX   = 4'(CLK_PER_PIX - 1);
    localparam logic [9:0]  H_OFF     = 10'(H_OFFSET);
    localparam logic [9:0]  H_END     = 10'(H_OFFSET + H_ACTIVE);
    localparam logic [9:0]  V_OFF     = 10'(V_OFFSET);
    localparam logic [9:0]  V_END     = 10'(V_OFFSET + V_ACTIVE);
    localparam logic [10:0] FRM_LINES = 11'(V_TOTAL);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state, state_n;
    logic [3:0]  good, good_n;
    logic        hs_q1, hs_q2, vs_q1, vs_q2;
    logic [11:0] rgb_q1, rgb_q2;
    logic        hs_fall, hs_rise, vs_fall, pix_tick;
    logic [12:0] hclk;
    logic [3:0]  div;
    logic [9:0]  hpix, vline;
    logic        hs_seen, vs_seen, nosync_armed;
    logic        line_bad, hsw_bad, frame_bad, nosync_hit;
    logic        err_now, err_any, pix_take;
    logic        e_line, e_hsw, e_frame, e_nosync;
    logic [7:0]  e_cnt;
    logic [9:0]  rx, ry;
    logic        rvon, pv;
    logic [11:0] prgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q1  <= 1'b0;
            hs_q2  <= 1'b0;
            vs_q1  <= 1'b0;
            vs_q2  <= 1'b0;
            rgb_q1 <= '0;
            rgb_q2 <= '0;
        end else begin
            hs_q1  <= bus.hsync;
            hs_q2  <= hs_q1;
            vs_q1  <= bus.vsync;
            vs_q2  <= vs_q1;
            rgb_q1 <= bus.rgb;
            rgb_q2 <= rgb_q1;
        end
    end

    assign hs_fall  = hs_q2 & ~hs_q1;
    assign hs_rise  = ~hs_q2 & hs_q1;
    assign vs_fall  = vs_q2 & ~vs_q1;
    assign pix_tick = (div == DIV_MAX);

    // Counters hold "events since last reference", so length = count + 1.
    assign line_bad  = hs_fall & hs_seen
                     & (({1'b0, hclk} + 14'd1) != LINE_CLKS);
    assign hsw_bad   = hs_rise & hs_seen
                     & (({1'b0, hclk} + 14'd1) != HSW_CLKS);
    assign frame_bad = vs_fall & vs_seen
                     & (({1'b0, vline} + 11'd1) != FRM_LINES);
    assign nosync_hit = nosync_armed & ~hs_fall & (hclk == NOSYNC_M1);

    assign err_now  = line_bad | hsw_bad | frame_bad | nosync_hit;
    assign err_any  = e_line | e_hsw | e_frame | e_nosync;
    assign pix_take = pix_tick & rvon & (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            hclk         <= '0;
            div          <= '0;
            hpix         <= '0;
            vline        <= '0;
            hs_seen      <= 1'b0;
            vs_seen      <= 1'b0;
            nosync_armed <= 1'b0;
        end else begin
            if (hs_fall)
                hclk <= '0;
            else if (hclk != 13'h1fff)
                hclk <= hclk + 13'd1;
            div <= (hs_fall | pix_tick) ? 4'd0 : div + 4'd1;
            if (hs_fall)
                hpix <= '0;
            else if (pix_tick && hpix != 10'h3ff)
                hpix <= hpix + 10'd1;
            if (vs_fall)
                vline <= '0;
            else if (hs_fall && vline != 10'h3ff)
                vline <= vline + 10'd1;
            if (hs_fall)
                hs_seen <= 1'b1;
            if (vs_fall)
                vs_seen <= 1'b1;
            if (hs_fall)
                nosync_armed <= 1'b1;
            else if (nosync_hit)
                nosync_armed <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_line   <= 1'b0;
            e_hsw    <= 1'b0;
            e_frame  <= 1'b0;
            e_nosync <= 1'b0;
            e_cnt    <= '0;
            rx       <= '0;
            ry       <= '0;
            rvon     <= 1'b0;
            pv       <= 1'b0;
            prgb     <= '0;
        end else begin
            e_line   <= line_bad;
            e_hsw    <= hsw_bad;
            e_frame  <= frame_bad;
            e_nosync <= nosync_hit;
            if (err_any && e_cnt != 8'hff)
                e_cnt <= e_cnt + 8'd1;
            rx   <= hpix - H_OFF;
            ry   <= vline - V_OFF;
            rvon <= (hpix >= H_OFF) && (hpix < H_END)
                 && (vline >= V_OFF) && (vline < V_END);
            pv   <= pix_take;
            if (pix_take)
                prgb <= rgb_q2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_n;
            good  <= good_n;
        end
    end

    // A frame counts as clean only if no error is pending or being raised.
    always_comb begin
        state_n = state;
        good_n  = good;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            ACQUIRE: begin
                if (err_any) begin
                    state_n = SEARCH;
                end else if (vs_fall && !err_now) begin
                    good_n = good + 4'd1;
                    if ((good + 4'd1) >= LOCK_N)
                        state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (err_any)
                    state_n = SEARCH;
            end
            default: state_n = SEARCH;
        endcase
    end

    assign bus.rec_x        = rx;
    assign bus.rec_y        = ry;
    assign bus.rec_video_on = rvon;
    assign bus.pix_valid    = pv;
    assign bus.pix_rgb      = prgb;
    assign bus.locked       = (state == LOCKED);
    assign bus.err_line     = e_line;
    assign bus.err_hsw      = e_hsw;
    assign bus.err_frame    = e_frame;
    assign bus.err_nosync   = e_nosync;
    assign bus.err_count    = e_cnt;
endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a scaled-down raster,
// with a pixel scoreboard filled by the source and drained on pix_valid.
module tb_vga_timing_decoder;
    localparam int CPP  = 2;
    localparam int HT   = 20;
    localparam int HSW  = 3;
    localparam int HOFF = 5;
    localparam int HACT = 12;
    localparam int VT   = 10;
    localparam int VOFF = 2;
    localparam int VACT = 6;
    localparam int LOCK = 3;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   npix = 0;
    int   pushed = 0;
    int   n_line = 0;
    int   n_hsw = 0;
    int   n_frame = 0;
    int   n_nosync = 0;
    pix_t sb[$];
    pix_t e;

    always #5 clk = ~clk;

    vga_timing_decoder_if bus();

    vga_timing_decoder #(
        .CLK_PER_PIX(CPP), .H_TOTAL(HT), .HS_W(HSW),
        .H_OFFSET(HOFF), .H_ACTIVE(HACT), .V_TOTAL(VT),
        .V_OFFSET(VOFF), .V_ACTIVE(VACT), .LOCK_FRAMES(LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] color(input int x, input int y);
        return 12'((x * 37 + y * 151 + 5) & 32'hfff);
    endfunction

    always @(negedge clk) begin
        if (bus.pix_valid) begin
            npix++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pix_x", 32'(bus.rec_x), 32'(e.x));
                chk("pix_y", 32'(bus.rec_y), 32'(e.y));
                chk("pix_rgb", 32'(bus.pix_rgb), 32'(e.c));
            end
        end
        if (bus.err_line)   n_line++;
        if (bus.err_hsw)    n_hsw++;
        if (bus.err_frame)  n_frame++;
        if (bus.err_nosync) n_nosync++;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rec_x"}, 32'(bus.rec_x), 0);
        chk({tag, "_rec_y"}, 32'(bus.rec_y), 0);
        chk({tag, "_von"}, 32'(bus.rec_video_on), 0);
        chk({tag, "_pv"}, 32'(bus.pix_valid), 0);
        chk({tag, "_prgb"}, 32'(bus.pix_rgb), 0);
        chk({tag, "_locked"}, 32'(bus.locked), 0);
        chk({tag, "_errs"}, 32'({bus.err_line, bus.err_hsw,
                                 bus.err_frame, bus.err_nosync}), 0);
        chk({tag, "_ecnt"}, 32'(bus.err_count), 0);
    endtask

    task automatic drive_line(input int ln, input int hsw, input int extra,
                              input bit push, input bit lock_edge,
                              input int rst_k);
        int total;
        total = HT * CPP + extra;
        for (int k = 0; k < total; k++) begin
            int h;
            int x;
            int y;
            h = k / CPP;
            x = h - HOFF;
            y = ln - VOFF;
            @(negedge clk);
            if (lock_edge && k == 1)
                chk("lock_before", 32'(bus.locked), 0);
            if (lock_edge && k == 2)
                chk("lock_after", 32'(bus.locked), 1);
            if (rst_k >= 0 && k == rst_k + 1) begin
                check_zero("midrst");
                rst = 1'b0;
            end
            bus.hsync = (h >= hsw);
            bus.vsync = (ln >= 2);
            bus.rgb   = color(x, y);
            if (push && (k % CPP) == 0 && h < HT
                && x >= 0 && x < HACT && y >= 0 && y < VACT) begin
                sb.push_back('{x: 10'(x), y: 10'(y), c: color(x, y)});
                pushed++;
            end
            if (k == rst_k)
                rst = 1'b1;
        end
    endtask

    task automatic drive_frame(input int lock_until, input int nlines,
                               input int st_line, input int st_extra,
                               input int sh_line, input bit lock_edge,
                               input int rst_line);
        int n0;
        pushed = 0;
        n0 = npix;
        for (int ln = 0; ln < nlines; ln++)
            drive_line(ln, (ln == sh_line) ? HSW - 1 : HSW,
                       (ln == st_line) ? st_extra : 0,
                       ln < lock_until, lock_edge && ln == 0,
                       (ln == rst_line) ? HT * CPP - 2 : -1);
        chk("frame_pix", 32'(npix - n0), 32'(pushed));
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.rgb = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int ln = 5; ln < VT; ln++)
            drive_line(ln, HSW, 0, 1'b0, 1'b0, -1);
        repeat (3) drive_frame(0, VT, -1, 0, -1, 1'b0, -1);
        drive_frame(VT, VT, -1, 0, -1, 1'b1, -1);
        chk("lock_full", 32'(VACT * HACT), 32'(pushed));
        chk("clean_errs", 32'(n_line + n_hsw + n_frame + n_nosync), 0);
        chk("clean_ecnt", 32'(bus.err_count), 0);

        drive_frame(5, VT, 4, 4, -1, 1'b0, -1);
        chk("stretch_nline", 32'(n_line), 1);
        chk("stretch_unlock", 32'(bus.locked), 0);
        chk("stretch_ecnt", 32'(bus.err_count), 1);
        repeat (3) drive_frame(0, VT, -1, 0, -1, 1'b0, -1);
        chk("relock_pending", 32'(bus.locked), 0);
        drive_frame(VT, VT, -1, 0, -1, 1'b1, -1);

        drive_frame(3, VT, -1, 0, 3, 1'b0, -1);
        chk("hsw_n", 32'(n_hsw), 1);
        chk("hsw_unlock", 32'(bus.locked), 0);
        chk("hsw_ecnt", 32'(bus.err_count), 2);

        drive_frame(0, VT - 1, -1, 0, -1, 1'b0, -1);
        drive_frame(0, VT, 1, 200, -1, 1'b0, -1);
        chk("frame_n", 32'(n_frame), 1);
        chk("nosync_n", 32'(n_nosync), 1);
        chk("nosync_line_n", 32'(n_line), 2);
        chk("nosync_ecnt", 32'(bus.err_count), 5);
        chk("nosync_unlock", 32'(bus.locked), 0);

        repeat (3) drive_frame(0, VT, -1, 0, -1, 1'b0, -1);
        drive_frame(5, VT, -1, 0, -1, 1'b1, 4);
        repeat (3) drive_frame(0, VT, -1, 0, -1, 1'b0, -1);
        drive_frame(VT, VT, -1, 0, -1, 1'b1, -1);
        chk("post_rst_errs", 32'(n_line + n_hsw + n_frame + n_nosync), 5);
        chk("post_rst_ecnt", 32'(bus.err_count), 0);
        chk("post_rst_lock", 32'(bus.locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
Receive-side counterpart of vga_sync: samples hsync, vsync and rgb as produced by the Pong display path and recovers pixel_x, pixel_y and video_on. Checks line, frame and sync-pulse timing against 640x480 parameters, runs a lock state machine, and emits a pixel-valid strobe with captured colour. Used as an on-chip/bench monitor beside Pong_Game_Animation_Top.

Parameters:
CLK_PER_PIX, 4, clk cycles per pixel (100 MHz clk, 25 MHz pixel)
H_TOTAL, 800, pixels per line
HS_W, 96, hsync low width in pixels
H_OFFSET, 144, pixels from hsync fall to first active pixel
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_OFFSET, 35, lines from vsync fall to first active line
V_ACTIVE, 480, active lines
LOCK_FRAMES, 3, consecutive clean frames needed to lock

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
hsync  in  1  active-low horizontal sync
vsync  in  1  active-low vertical sync
rgb  in  12  pixel colour
rec_x  out  10  recovered pixel column (valid when rec_video_on)
rec_y  out  10  recovered line
rec_video_on  out  1  recovered active-area flag
pix_valid  out  1  one-clk strobe per active pixel, only when locked
pix_rgb  out  12  rgb captured with pix_valid
locked  out  1  lock FSM in LOCKED
err_line  out  1  one-clk pulse: line length mismatch
err_hsw  out  1  one-clk pulse: hsync width mismatch
err_frame  out  1  one-clk pulse: frame line count mismatch
err_nosync  out  1  one-clk pulse: hsync timeout
err_count  out  8  saturating count of all error pulses

Behaviour:
- Clock domain: clk only; reset is synchronous and active-high. All outputs 0 on reset; FSM=SEARCH; all reference-seen flags cleared.
- Inputs registered twice (q1, q2); hs_fall = q2 & ~q1 (likewise vs_fall, hs_rise). rgb delayed two stages to align. Pin-to-event latency 2 clks.
- hclk (13 b): cleared to 0 on hs_fall, otherwise +1, saturating at 8191. On hs_fall with prior hs_fall seen: err_line if hclk+1 != H_TOTAL*CLK_PER_PIX.
- On hs_rise: err_hsw if clocks since hs_fall != HS_W*CLK_PER_PIX (only after an hs_fall has been seen).
- err_nosync pulses once when hclk reaches 2*H_TOTAL*CLK_PER_PIX; re-arms on next hs_fall.
- Pixel divider: div cleared on hs_fall, pix_tick when div==CLK_PER_PIX-1, then wraps to 0. hpix (10 b) cleared on hs_fall, +1 per pix_tick, saturating at 1023.
- vline (10 b): +1 on hs_fall, saturating at 1023; vs_fall sets vline=0 and overrides a simultaneous hs_fall. On vs_fall with prior vs_fall seen: err_frame if line count since prior vs_fall != V_TOTAL.
- rec_x = hpix-H_OFFSET; rec_y = vline-V_OFFSET (10-b wrap). rec_video_on = hpix in [H_OFFSET, H_OFFSET+H_ACTIVE) and vline in [V_OFFSET, V_OFFSET+V_ACTIVE). Registered, 1 clk after counters.
- pix_valid = pix_tick & rec_video_on & locked; pix_rgb loaded in the same cycle and held otherwise.
- Lock FSM:
  - SEARCH: on vs_fall -> ACQUIRE with good=0.
  - ACQUIRE: frame_err flag collects any error since last vs_fall. On a clean vs_fall, good+1; reaching LOCK_FRAMES -> LOCKED.
  - LOCKED: holds while clean.
  - Any error pulse in ACQUIRE or LOCKED -> SEARCH the next clk (error wins over a simultaneous vs_fall).
- err_count increments by 1 per cycle in which any err_* is high, saturating at 255; cleared only by rst.
- Reset mid-frame: all state cleared; the first line and frame after reset are never flagged.

Test Plan:
- Drive from vga_sync, clean 640x480 -> no err pulses; locked rises 1 clk after the 4th vs_fall; 307200 pix_valid per locked frame.
- Locked, colour bars at x=0 and x=639 -> pix_valid with rec_x=0/639 and matching pix_rgb; rec_y 0..479.
- One line stretched by 4 clks -> single err_line, locked drops, err_count=1, relock after 4 further vs_fall.
- hsync pulse shortened to 95 px -> err_hsw at hs_rise, FSM SEARCH.
- Frame of 524 lines -> err_frame at vs_fall; hsync held high 6400 clks -> exactly one err_nosync.
- Assert rst mid-line while locked -> all outputs 0 next clk; first post-reset line and frame produce no errors.
